ysyx_24120013_imem_responder: RTL and testbench

- Instruction-memory responder: the slave end of the core's fetch interface.
- Receives PC fetch requests over a valid/ready channel and returns the 32-bit instruction word after a configurable latency on a second valid/ready channel.
- Holds word-addressed storage that the bench or loader programs through a side write port.
- Replaces the direct combinational pmem feed; only one request is outstanding at a time.

---
 rtl/ysyx_24120013_imem_responder_pkg.sv | 16 +
 rtl/ysyx_24120013_imem_responder_if.sv | 24 ++
 rtl/ysyx_24120013_imem_responder_array.sv | 28 ++
 rtl/ysyx_24120013_imem_responder.sv | 113 +++++++++++
 tb/tb_ysyx_24120013_imem_responder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_24120013_imem_responder_pkg.sv
// Shared definitions for the fetch path: responder FSM states and reset PC/NOP constants.
package ysyx_24120013_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // First fetch address after reset; also the byte address of imem word 0.
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // addi x0,x0,0 -- what the core should issue in place of a faulted fetch.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24120013_imem_responder_if.sv
// Fetch channel between core (master) and instruction memory (slave):
// request valid/ready carrying the PC, response valid/ready carrying the word.
interface ysyx_24120013_imem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_inst;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_24120013_imem_responder_array.sv
// Word RAM: synchronous program-write port plus one read port whose data is
// captured into an output register on read enable and held until the next read.
module ysyx_24120013_imem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  // Read capture; a same-edge write to raddr is not yet visible, so the old word is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ysyx_24120013_imem_responder.sv
// Instruction-memory responder: accepts one PC fetch at a time, returns the
// stored word (or a fetch fault) LATENCY cycles later, holds it under backpressure.
module ysyx_24120013_imem_responder
  import ysyx_24120013_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RESET_PC),
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24120013_imem_responder_if.slave bus,
  input  logic                  prog_wen,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data
);
  localparam int                    CW       = $clog2(LATENCY + 1);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] WORDS    = ADDR_WIDTH'(2 ** DEPTH_LOG2);

  imem_state_t           state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  err_q;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] off, word;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] rd_data;

  // Byte address -> word index relative to BASE_ADDR; unsigned wrap below base is caught by the < test.
  assign off     = bus.req_addr - BASE_ADDR;
  assign word    = off >> 2;
  assign dec_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) || (word >= WORDS);

  assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // FSM, latency counter and captured fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) err_q <= dec_err;
    end
  end

  // Next state: an accepted request (from IDLE or on the RESP handshake) reloads the latency.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            cnt_n   = '0;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            cnt_n   = '0;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end else if (bus.rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_inst  = ((state == RESP) && !err_q) ? rd_data : '0;

  ysyx_24120013_imem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wen   (prog_wen),
    .waddr (prog_addr),
    .wdata (prog_data),
    .ren   (accept),
    .raddr (word[DEPTH_LOG2-1:0]),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_ysyx_24120013_imem_responder.sv
// Directed bench: a LATENCY=2 responder for timing/backpressure/fault/hazard/reset
// and a LATENCY=1 responder for back-to-back throughput, sharing the program port.
module tb_ysyx_24120013_imem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_wen = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  int          total = 0;
  int          bad = 0;

  ysyx_24120013_imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  ysyx_24120013_imem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  ysyx_24120013_imem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst_n), .bus(bus2.slave),
    .prog_wen(prog_wen), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  ysyx_24120013_imem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_n), .bus(bus1.slave),
    .prog_wen(prog_wen), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [9:0] a, input logic [31:0] d);
    prog_wen = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1 prog_wen = 1'b0;
  endtask

  // One LATENCY=2 fetch with rsp_ready already high; starts and ends away from posedge.
  task automatic fetch2(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_inst, input logic exp_err);
    bus2.req_valid = 1'b1; bus2.req_addr = addr;
    @(posedge clk); #1 bus2.req_valid = 1'b0; prog_wen = 1'b0;
    @(negedge clk);
    chk({tag, ".wait_vld"}, 32'(bus2.rsp_valid), 32'd0);
    chk({tag, ".wait_rdy"}, 32'(bus2.req_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".vld"}, 32'(bus2.rsp_valid), 32'd1);
    chk({tag, ".inst"}, bus2.rsp_inst, exp_inst);
    chk({tag, ".err"}, 32'(bus2.rsp_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_inst [3];

  initial begin
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.vld", 32'(bus2.rsp_valid), 32'd0);
    chk("rst.err", 32'(bus2.rsp_err), 32'd0);
    chk("rst.inst", bus2.rsp_inst, 32'd0);
    chk("rst.rdy", 32'(bus2.req_ready), 32'd1);
    rst_n = 1'b1;

    // Program image
    @(posedge clk); #1;
    prog(10'd0, 32'h0010_0093);
    prog(10'd1, 32'h0020_0113);
    prog(10'd2, 32'h0030_0193);
    prog(10'd3, 32'hAAAA_0003);
    prog(10'd1023, 32'hDEAD_BEEF);

    // Basic fetch, rsp_valid two edges after acceptance
    fetch2("basic", 32'h8000_0000, 32'h0010_0093, 1'b0);

    // Back-to-back on LATENCY=1: one response per cycle, in order
    b2b_addr[0] = 32'h8000_0000; b2b_inst[0] = 32'h0010_0093;
    b2b_addr[1] = 32'h8000_0004; b2b_inst[1] = 32'h0020_0113;
    b2b_addr[2] = 32'h8000_0008; b2b_inst[2] = 32'h0030_0193;
    bus1.req_valid = 1'b1; bus1.req_addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) bus1.req_addr = b2b_addr[i+1];
      else       bus1.req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b%0d.vld", i), 32'(bus1.rsp_valid), 32'd1);
      chk($sformatf("b2b%0d.inst", i), bus1.rsp_inst, b2b_inst[i]);
      chk($sformatf("b2b%0d.rdy", i), 32'(bus1.req_ready), 32'd1);
    end
    @(negedge clk);
    chk("b2b.idle_vld", 32'(bus1.rsp_valid), 32'd0);

    // Backpressure: outputs hold for 5 cycles, a prog write meanwhile must not leak in
    bus2.rsp_ready = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h8000_0004;
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.vld", i), 32'(bus2.rsp_valid), 32'd1);
      chk($sformatf("bp%0d.inst", i), bus2.rsp_inst, 32'h0020_0113);
      chk($sformatf("bp%0d.err", i), 32'(bus2.rsp_err), 32'd0);
      if (i == 0) begin prog_wen = 1'b1; prog_addr = 10'd1; prog_data = 32'hBAD0_0001; end
      @(posedge clk); #1 prog_wen = 1'b0;
      @(negedge clk);
    end
    bus2.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.after_vld", 32'(bus2.rsp_valid), 32'd0);
    chk("bp.after_rdy", 32'(bus2.req_ready), 32'd1);
    @(posedge clk); #1;

    // Fetch faults and the last valid word
    fetch2("mis", 32'h8000_0002, 32'd0, 1'b1);
    fetch2("low", 32'h7FFF_FFFC, 32'd0, 1'b1);
    fetch2("oor", 32'h8000_1000, 32'd0, 1'b1);
    fetch2("last", 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);

    // Same-edge write and fetch of idx 3: old word first, new word after
    prog_wen = 1'b1; prog_addr = 10'd3; prog_data = 32'h1234_5678;
    fetch2("hz_old", 32'h8000_000C, 32'hAAAA_0003, 1'b0);
    fetch2("hz_new", 32'h8000_000C, 32'h1234_5678, 1'b0);

    // Reset while presenting a response: outputs drop without a clock edge
    bus2.rsp_ready = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h8000_0000;
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr.vld_before", 32'(bus2.rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr.vld", 32'(bus2.rsp_valid), 32'd0);
    chk("rr.inst", bus2.rsp_inst, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus2.rsp_ready = 1'b1;

    // Reset during WAIT: no stale response afterwards, storage kept
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h8000_0008;
    @(posedge clk); #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    chk("rw.wait_rdy", 32'(bus2.req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rw%0d.vld", i), 32'(bus2.rsp_valid), 32'd0);
      chk($sformatf("rw%0d.rdy", i), 32'(bus2.req_ready), 32'd1);
    end
    fetch2("keep0", 32'h8000_0000, 32'h0010_0093, 1'b0);
    fetch2("keep1", 32'h8000_0004, 32'hBAD0_0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
